// File: rtl/cpu_debug_console_pkg.sv
// Shared encodings for the CPU debug console: run modes, clock FSM states
// and the fixed 7-segment patterns.
package cpu_debug_console_pkg;

   localparam logic [1:0] MODE_RUN  = 2'b00;
   localparam logic [1:0] MODE_STEP = 2'b01;
   localparam logic [1:0] MODE_HOLD = 2'b10;
   localparam logic [1:0] MODE_FAST = 2'b11;

   typedef enum logic [1:0] {
      PARK = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } clk_state_e;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/cpu_debug_console_seg7_hex_decoder.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} segments; invalid data shows a dash.
module seg7_hex_decoder
   import cpu_debug_console_pkg::*;
(
   input  logic [3:0] val,
   input  logic       valid,
   output logic [6:0] seg
);

   logic [6:0] hex;

   always_comb begin
      hex = SEG_BLANK;
      case (val)
         4'h0: hex = 7'b1000000;
         4'h1: hex = 7'b1111001;
         4'h2: hex = 7'b0100100;
         4'h3: hex = 7'b0110000;
         4'h4: hex = 7'b0011001;
         4'h5: hex = 7'b0010010;
         4'h6: hex = 7'b0000010;
         4'h7: hex = 7'b1111000;
         4'h8: hex = 7'b0000000;
         4'h9: hex = 7'b0010000;
         4'hA: hex = 7'b0001000;
         4'hB: hex = 7'b0000011;
         4'hC: hex = 7'b1000110;
         4'hD: hex = 7'b0100001;
         4'hE: hex = 7'b0000110;
         4'hF: hex = 7'b0001110;
         default: hex = SEG_BLANK;
      endcase
      seg = valid ? hex : SEG_DASH;
   end

endmodule

// File: rtl/cpu_debug_console.sv
// Board debug front end: slow CPU clock generator with run/step/hold/fast
// modes, debounced step button, and a multiplexed 7-segment probe display.
module cpu_debug_console
   import cpu_debug_console_pkg::*;
#(
   parameter  int DIV_HALF  = 50_000_000,
   parameter  int FAST_HALF = 5_000_000,
   parameter  int NUM_CH    = 4,
   parameter  int DIGITS    = 4,
   parameter  int SCAN_DIV  = 100_000,
   parameter  int DEBOUNCE  = 1_000_000,
   localparam int DATA_W    = 4*DIGITS,
   localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               mode,
   input  logic                     step_btn,
   input  logic [SEL_W-1:0]         ch_sel,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic                     cpu_clk,
   output logic                     cpu_tick,
   output logic [6:0]               seg,
   output logic [DIGITS-1:0]        an,
   output logic                     dp
);

   localparam int MAXH = (DIV_HALF > FAST_HALF) ? DIV_HALF : FAST_HALF;
   localparam int CW   = $clog2(MAXH + 1);
   localparam int DW   = $clog2(DEBOUNCE + 1);
   localparam int SW   = $clog2(SCAN_DIV + 1);
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // ---------------- step button debounce ----------------
   logic          btn_s1, btn_s2, btn_lvl, press;
   logic [DW-1:0] db_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_s1  <= 1'b0;
         btn_s2  <= 1'b0;
         btn_lvl <= 1'b0;
         press   <= 1'b0;
         db_cnt  <= '0;
      end else begin
         btn_s1 <= step_btn;
         btn_s2 <= btn_s1;
         press  <= 1'b0;
         if (btn_s2 == btn_lvl)
            db_cnt <= '0;
         else if (db_cnt == DW'(DEBOUNCE - 1)) begin
            btn_lvl <= btn_s2;
            db_cnt  <= '0;
            press   <= btn_s2;
         end else
            db_cnt <= db_cnt + 1'b1;
      end
   end

   // ---------------- CPU clock FSM ----------------
   clk_state_e    state, state_n;
   logic [CW-1:0] cnt, cnt_n, half, half_n, run_half;
   logic          clk_n, tick_n, run, term;

   assign run      = (mode == MODE_RUN) || (mode == MODE_FAST);
   assign run_half = (mode == MODE_FAST) ? CW'(FAST_HALF) : CW'(DIV_HALF);
   assign term     = (cnt == half - 1'b1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= PARK;
         cnt      <= '0;
         half     <= '0;
         cpu_clk  <= 1'b0;
         cpu_tick <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         half     <= half_n;
         cpu_clk  <= clk_n;
         cpu_tick <= tick_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      half_n  = half;
      clk_n   = cpu_clk;
      tick_n  = 1'b0;
      case (state)
         PARK: begin
            cnt_n = '0;
            clk_n = 1'b0;
            if (run) begin
               state_n = LOW;
               half_n  = run_half;
            end else if (mode == MODE_STEP && press) begin
               state_n = HIGH;
               clk_n   = 1'b1;
               tick_n  = 1'b1;
               half_n  = CW'(FAST_HALF);
            end
         end
         LOW: begin
            // Leaving for PARK while low cannot produce a runt pulse.
            if (!run) begin
               state_n = PARK;
               cnt_n   = '0;
            end else if (term) begin
               state_n = HIGH;
               clk_n   = 1'b1;
               tick_n  = 1'b1;
               cnt_n   = '0;
               half_n  = run_half;
            end
         end
         HIGH: begin
            if (term) begin
               clk_n = 1'b0;
               cnt_n = '0;
               if (run) begin
                  state_n = LOW;
                  half_n  = run_half;
               end else
                  state_n = PARK;
            end
         end
         default: begin
            state_n = PARK;
            cnt_n   = '0;
            clk_n   = 1'b0;
         end
      endcase
   end

   // ---------------- display scan ----------------
   logic [SW-1:0]     sc;
   logic [IW-1:0]     idx;
   logic [DATA_W-1:0] word, sel_word;
   logic              word_ok, loaded, slot_end, scan_wrap;
   logic [6:0]        hex_seg;

   assign slot_end  = (sc == SW'(SCAN_DIV - 1));
   assign scan_wrap = slot_end && (idx == IW'(DIGITS - 1));

   always_comb begin
      sel_word = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (int'(ch_sel) == k) sel_word = ch_data[k*DATA_W +: DATA_W];
   end

   seg7_hex_decoder u_dec (
      .val   (word[{idx, 2'b00} +: 4]),
      .valid (word_ok),
      .seg   (hex_seg)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sc      <= '0;
         idx     <= '0;
         word    <= '0;
         word_ok <= 1'b0;
         loaded  <= 1'b0;
         seg     <= SEG_BLANK;
         an      <= '1;
         dp      <= 1'b1;
      end else begin
         sc <= slot_end ? '0 : sc + 1'b1;
         if (slot_end) idx <= scan_wrap ? '0 : idx + 1'b1;
         // Word is only refreshed between scans so a frame never mixes sources.
         if (!loaded || scan_wrap) begin
            word    <= sel_word;
            word_ok <= (int'(ch_sel) < NUM_CH);
            loaded  <= 1'b1;
         end
         seg <= loaded ? hex_seg : SEG_BLANK;
         an  <= ~(DIGITS'(1) << idx);
         dp  <= !((idx == '0) && (state == PARK));
      end
   end

endmodule
